// File: rtl/ysyx_22041071_mdu_seq.sv
// Multi-cycle M-extension sequencer: 1-bit/cycle shift-add multiplier and restoring divider
// sharing one 2*XLEN working register, with valid/ready on both sides.
module ysyx_22041071_mdu_seq #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned OP_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [OP_W-1:0] op_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic [4:0]      rdest_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rdest_o,
  output logic            busy_o
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam int unsigned AW = 2 * XLEN;

  localparam logic [OP_W-1:0] OpMul   = OP_W'(19);
  localparam logic [OP_W-1:0] OpMulh  = OP_W'(20);
  localparam logic [OP_W-1:0] OpMulhu = OP_W'(21);
  localparam logic [OP_W-1:0] OpMulw  = OP_W'(22);
  localparam logic [OP_W-1:0] OpDiv   = OP_W'(23);
  localparam logic [OP_W-1:0] OpDivu  = OP_W'(24);
  localparam logic [OP_W-1:0] OpDivw  = OP_W'(25);
  localparam logic [OP_W-1:0] OpDivuw = OP_W'(26);
  localparam logic [OP_W-1:0] OpRem   = OP_W'(27);
  localparam logic [OP_W-1:0] OpRemu  = OP_W'(28);
  localparam logic [OP_W-1:0] OpRemuw = OP_W'(29);
  localparam logic [OP_W-1:0] OpRemw  = OP_W'(30);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [4:0]      rdest_q, rdest_d;
  logic            neg_q, neg_d;
  logic            w_q, w_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] result_q, result_d;

  // Input decode
  logic            is_mul_in, is_div_in, w_in, sgn_in, rem_in, div_zero, ovf, fast;
  logic            a_neg, b_neg, neg_in;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
  logic [AW-1:0]   acc_init;

  always_comb begin
    is_mul_in = (op_i >= OpMul) && (op_i <= OpMulw);
    is_div_in = (op_i >= OpDiv) && (op_i <= OpRemw);
    w_in      = (op_i == OpMulw) || (op_i == OpDivw) || (op_i == OpDivuw) ||
                (op_i == OpRemuw) || (op_i == OpRemw);
    sgn_in    = (op_i == OpMulh) || (op_i == OpDiv) || (op_i == OpDivw) ||
                (op_i == OpRem) || (op_i == OpRemw);
    rem_in    = (op_i >= OpRem) && (op_i <= OpRemw);
    if (w_in) begin
      a_ext = {{(XLEN-32){sgn_in & src_a_i[31]}}, src_a_i[31:0]};
      b_ext = {{(XLEN-32){sgn_in & src_b_i[31]}}, src_b_i[31:0]};
    end else begin
      a_ext = src_a_i;
      b_ext = src_b_i;
    end
    a_neg    = sgn_in & a_ext[XLEN-1];
    b_neg    = sgn_in & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    neg_in   = rem_in ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div_in && (b_ext == '0);
    ovf      = is_div_in && sgn_in && (b_ext == '1) &&
               (w_in ? (src_a_i[31:0] == 32'h8000_0000)
                     : (src_a_i == {1'b1, {(XLEN-1){1'b0}}}));
    fast     = !(is_mul_in || is_div_in) || div_zero || ovf;

    // Fast-path cases preload the register so the common finish logic yields the answer.
    acc_init = '0;
    if (is_mul_in) begin
      acc_init = {{XLEN{1'b0}}, b_mag};
    end else if (div_zero) begin
      acc_init = {a_ext, {XLEN{1'b1}}};
    end else if (ovf) begin
      acc_init = {{XLEN{1'b0}}, a_ext};
    end else if (is_div_in) begin
      acc_init = w_in ? {{XLEN{1'b0}}, a_mag[31:0], {(XLEN-32){1'b0}}}
                      : {{XLEN{1'b0}}, a_mag};
    end
  end

  // Iteration steps
  logic [XLEN:0]   mul_sum, div_hi, div_diff;
  logic            div_ge;
  logic [AW-1:0]   mul_next, div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_hi   = acc_q[AW-1:XLEN-1];
    div_ge   = div_hi >= {1'b0, opnd_q};
    div_diff = div_hi - {1'b0, opnd_q};
    div_next = {div_ge ? div_diff[XLEN-1:0] : div_hi[XLEN-1:0], acc_q[XLEN-2:0], div_ge};
  end

  // Result selection and final negate
  logic [AW-1:0]   prod_n;
  logic [XLEN-1:0] quot, dv, dv_n, fin;

  always_comb begin
    prod_n = neg_q ? -acc_q : acc_q;
    quot   = w_q ? {{(XLEN-32){1'b0}}, acc_q[31:0]} : acc_q[XLEN-1:0];
    dv     = (op_q >= OpRem) ? acc_q[AW-1:XLEN] : quot;
    dv_n   = neg_q ? -dv : dv;
    fin    = '0;
    case (op_q)
      OpMul:           fin = prod_n[XLEN-1:0];
      OpMulh, OpMulhu: fin = prod_n[AW-1:XLEN];
      // After 32 steps the low word of the product sits just below bit XLEN.
      OpMulw:          fin = {{(XLEN-32){acc_q[XLEN-1]}}, acc_q[XLEN-1:XLEN-32]};
      OpDiv, OpDivu, OpDivw, OpDivuw, OpRem, OpRemu, OpRemuw, OpRemw:
        fin = w_q ? {{(XLEN-32){dv_n[31]}}, dv_n[31:0]} : dv_n;
      default:         fin = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    rdest_d  = rdest_q;
    neg_d    = neg_q;
    w_d      = w_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          op_d    = op_i;
          rdest_d = rdest_i;
          w_d     = w_in;
          neg_d   = fast ? 1'b0 : (neg_in & sgn_in);
          acc_d   = acc_init;
          opnd_d  = is_mul_in ? a_mag : b_mag;
          count_d = fast ? '0 : (w_in ? CW'(32) : CW'(XLEN));
          state_d = (is_mul_in && !fast) ? StMul : StDiv;
        end
      end
      StMul, StDiv: begin
        if (count_q == '0) begin
          result_d = fin;
          state_d  = StDone;
        end else begin
          acc_d   = (state_q == StMul) ? mul_next : div_next;
          count_d = count_q - CW'(1);
        end
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush_i) begin
      state_d = StIdle;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      count_q  <= '0;
      op_q     <= '0;
      rdest_q  <= '0;
      neg_q    <= 1'b0;
      w_q      <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      rdest_q  <= rdest_d;
      neg_q    <= neg_d;
      w_q      <= w_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign busy_o      = ~in_ready_o;
  assign out_valid_o = (state_q == StDone);
  assign result_o    = result_q;
  assign rdest_o     = rdest_q;

endmodule

// File: tb/tb_ysyx_22041071_mdu_seq.sv
// Scoreboard bench for the mul/div sequencer: directed ops, flush, back-pressure, async reset.
module tb_ysyx_22041071_mdu_seq;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [4:0]  op, rdest_in, rdest_out;
  logic [63:0] src_a, src_b, result;

  ysyx_22041071_mdu_seq #(.XLEN(64), .OP_W(5)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .op_i       (op),
    .src_a_i    (src_a),
    .src_b_i    (src_b),
    .rdest_i    (rdest_in),
    .flush_i    (flush),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result),
    .rdest_o    (rdest_out),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   accept_cyc = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  initial begin
    bit seen = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_ni && out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          if (!seen) begin
            check("latency", 64'(cyc - accept_cyc), 64'(sb[0].lat));
            check("in_ready_in_done", 64'(in_ready), 64'd0);
            seen = 1;
          end
          check("result", result, sb[0].res);
          check("rdest", 64'(rdest_out), 64'(sb[0].rd));
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    #1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("wait_in_ready_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic issue(input logic [4:0] o, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input logic [63:0] exp, input int lat,
                       input bit push);
    exp_t e;
    wait_ready();
    e.res = exp;
    e.rd  = rd;
    e.lat = lat;
    if (push) sb.push_back(e);
    op       = o;
    src_a    = a;
    src_b    = b;
    rdest_in = rd;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    in_valid   = 1'b0;
  endtask

  initial begin
    int n;
    rst_ni = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    op = '0; src_a = '0; src_b = '0; rdest_in = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_rdest", 64'(rdest_out), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    issue(5'd19, 64'd3, -64'sd5, 5'd1, 64'hFFFF_FFFF_FFFF_FFF1, 65, 1);
    issue(5'd21, '1, '1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1);
    issue(5'd20, '1, '1, 5'd3, 64'd0, 65, 1);
    issue(5'd25, -64'sd7, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD, 33, 1);
    issue(5'd30, -64'sd7, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 33, 1);
    issue(5'd23, 64'd100, 64'd0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1);
    issue(5'd27, 64'h8000_0000_0000_0000, '1, 5'd7, 64'd0, 1, 1);
    issue(5'd23, 64'h8000_0000_0000_0000, '1, 5'd8, 64'h8000_0000_0000_0000, 1, 1);
    issue(5'd25, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd9,
          64'hFFFF_FFFF_8000_0000, 1, 1);
    issue(5'd22, 64'h1234_5678_7FFF_FFFF, 64'd2, 5'd10, 64'hFFFF_FFFF_FFFF_FFFE, 33, 1);
    issue(5'd24, 64'd100, 64'd7, 5'd11, 64'd14, 65, 1);
    issue(5'd23, -64'sd7, 64'd2, 5'd12, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1);
    issue(5'd27, -64'sd7, 64'd2, 5'd13, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1);
    issue(5'd26, 64'd5, 64'h1_0000_0000, 5'd14, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1);
    issue(5'd29, 64'h0000_0000_8000_0001, 64'h1_0000_0000, 5'd15,
          64'hFFFF_FFFF_8000_0001, 1, 1);
    issue(5'd31, 64'd9, 64'd9, 5'd16, 64'd0, 1, 1);
    issue(5'd0, 64'd9, 64'd9, 5'd17, 64'd0, 1, 1);

    // Flush mid-divide: no result may ever appear for it.
    issue(5'd24, 64'd1000, 64'd3, 5'd18, 64'd0, 0, 0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    // Op presented together with flush in IDLE must be dropped.
    op = 5'd19; src_a = 64'd1; src_b = 64'd1; rdest_in = 5'd19;
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    #1;
    check("flush_blocks_accept", 64'(in_ready), 64'd1);
    repeat (80) @(negedge clk);
    issue(5'd24, 64'd1000, 64'd10, 5'd20, 64'd100, 65, 1);

    // Back-pressure in DONE.
    wait_ready();
    out_ready = 1'b0;
    issue(5'd28, 64'd100, 64'd7, 5'd21, 64'd2, 65, 1);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("stall_out_valid", 64'(out_valid), 64'd1);
    repeat (5) @(negedge clk);
    #1;
    check("stall_hold_valid", 64'(out_valid), 64'd1);
    check("stall_hold_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("handshake_out_valid", 64'(out_valid), 64'd0);
    check("handshake_in_ready", 64'(in_ready), 64'd1);

    // Async reset mid-multiply.
    issue(5'd19, 64'd7, 64'd9, 5'd22, 64'd0, 0, 0);
    repeat (20) @(negedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_result", result, 64'd0);
    check("arst_rdest", 64'(rdest_out), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_ni = 1'b1;
    issue(5'd19, 64'd7, 64'd9, 5'd23, 64'd63, 65, 1);

    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
